alu_simd: RTL and testbench

Parametrised, pipelined packed-SIMD integer ALU and successor to the scalar ALU. It splits an XLEN-bit operand pair into 8/16/32/64-bit lanes selected per operation. Each lane gets add/sub (wrapping or saturating), min/max, compare masks, shifts and logic ops. The block sits beside the scalar ALU in the execute stage and uses a valid/ready handshake with a transaction-ID passthrough. A sticky saturation flag register provides the CSR-visible overflow status.

---
 rtl/alu_simd.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_alu_simd.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_simd.sv
// Packed-SIMD integer ALU with 8/16/32/64-bit lanes, an elastic valid/ready
// pipeline that carries a transaction tag, and a sticky saturation flag.

package alu_simd_pkg;
   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_ADDSS  = 5'd2,
      OP_ADDUS  = 5'd3,
      OP_SUBSS  = 5'd4,
      OP_SUBUS  = 5'd5,
      OP_MIN    = 5'd6,
      OP_MAX    = 5'd7,
      OP_MINU   = 5'd8,
      OP_MAXU   = 5'd9,
      OP_CMPEQ  = 5'd10,
      OP_CMPLT  = 5'd11,
      OP_CMPLTU = 5'd12,
      OP_SLL    = 5'd13,
      OP_SRL    = 5'd14,
      OP_SRA    = 5'd15,
      OP_AND    = 5'd16,
      OP_OR     = 5'd17,
      OP_XOR    = 5'd18
   } op_e;
endpackage

// One W-bit lane; purely combinational.
module alu_simd_lane
   import alu_simd_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [4:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] res,
   output logic         sat
);
   localparam int           SW   = $clog2(W);
   localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

   logic [W:0]    sum_u;
   logic [W:0]    dif_u;
   logic [W:0]    sum_s;
   logic [W:0]    dif_s;
   logic          lt_s;
   logic          lt_u;
   logic [SW-1:0] shamt;

   assign sum_u = {1'b0, a} + {1'b0, b};
   assign dif_u = {1'b0, a} - {1'b0, b};
   assign sum_s = {a[W-1], a} + {b[W-1], b};
   assign dif_s = {a[W-1], a} - {b[W-1], b};
   assign lt_s  = $signed(a) < $signed(b);
   assign lt_u  = a < b;
   assign shamt = b[SW-1:0];

   // NOTE: res and sat get a default before the case so no path through it
   // leaves them unassigned, which would otherwise infer a latch.
   always_comb begin
      res = '0;
      sat = 1'b0;
      case (op_e'(op))
         OP_ADD: res = sum_u[W-1:0];
         OP_SUB: res = dif_u[W-1:0];
         OP_ADDSS: begin
            // W+1-bit signed result overflowed W bits when its top two bits differ
            res = sum_s[W-1:0];
            if (sum_s[W] != sum_s[W-1]) begin
               res = sum_s[W] ? SMIN : SMAX;
               sat = 1'b1;
            end
         end
         OP_ADDUS: begin
            res = sum_u[W] ? '1 : sum_u[W-1:0];
            sat = sum_u[W];
         end
         OP_SUBSS: begin
            res = dif_s[W-1:0];
            if (dif_s[W] != dif_s[W-1]) begin
               res = dif_s[W] ? SMIN : SMAX;
               sat = 1'b1;
            end
         end
         OP_SUBUS: begin
            res = dif_u[W] ? '0 : dif_u[W-1:0];
            sat = dif_u[W];
         end
         OP_MIN:    res = lt_s ? a : b;
         OP_MAX:    res = lt_s ? b : a;
         OP_MINU:   res = lt_u ? a : b;
         OP_MAXU:   res = lt_u ? b : a;
         OP_CMPEQ:  res = {W{a == b}};
         OP_CMPLT:  res = {W{lt_s}};
         OP_CMPLTU: res = {W{lt_u}};
         OP_SLL:    res = a << shamt;
         OP_SRL:    res = a >> shamt;
         OP_SRA:    res = $signed(a) >>> shamt;
         OP_AND:    res = a & b;
         OP_OR:     res = a | b;
         OP_XOR:    res = a ^ b;
         default: ;
      endcase
   end
endmodule

module alu_simd #(
   parameter int XLEN          = 64,
   parameter int PIPE_DEPTH    = 2,
   parameter int TRANS_ID_BITS = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [4:0]               op_i,
   input  logic [1:0]               ew_i,
   input  logic [XLEN-1:0]          operand_a_i,
   input  logic [XLEN-1:0]          operand_b_i,
   input  logic [TRANS_ID_BITS-1:0] trans_id_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [XLEN-1:0]          result_o,
   output logic [TRANS_ID_BITS-1:0] trans_id_o,
   output logic                     sat_o,
   output logic                     sat_sticky_o,
   input  logic                     clear_sat_i
);
   logic [PIPE_DEPTH-1:0]    vld;
   logic [PIPE_DEPTH-1:0]    go;
   logic [4:0]               op_q;
   logic [1:0]               ew_q;
   logic [1:0]               ew_eff;
   logic [XLEN-1:0]          a_q;
   logic [XLEN-1:0]          b_q;
   logic [TRANS_ID_BITS-1:0] id_q;
   logic                     sticky;

   logic [XLEN-1:0]          res8;
   logic [XLEN-1:0]          res16;
   logic [XLEN-1:0]          res32;
   logic [XLEN-1:0]          res64;
   logic [XLEN/8-1:0]        sat8;
   logic [XLEN/16-1:0]       sat16;
   logic [XLEN/32-1:0]       sat32;
   logic                     sat64;
   logic [XLEN-1:0]          lane_res;
   logic                     lane_sat;

   // Stage k may load when the output is taken or any stage from k onward is empty.
   always_comb begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
         go[k] = ready_i;
         for (int j = k; j < PIPE_DEPTH; j++) begin
            if (!vld[j]) go[k] = 1'b1;
         end
      end
   end

   assign ready_o      = go[0] | rst_i;
   assign valid_o      = vld[PIPE_DEPTH-1];
   assign sat_sticky_o = sticky;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld  <= '0;
         op_q <= '0;
         ew_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
         id_q <= '0;
      end else begin
         if (go[0]) begin
            vld[0] <= valid_i;
            op_q   <= op_i;
            ew_q   <= ew_i;
            a_q    <= operand_a_i;
            b_q    <= operand_b_i;
            id_q   <= trans_id_i;
         end
         for (int k = 1; k < PIPE_DEPTH; k++) begin
            if (go[k]) vld[k] <= vld[k-1];
         end
      end
   end

   for (genvar i = 0; i < XLEN/8; i++) begin : g_l8
      alu_simd_lane #(.W(8)) u_lane (
         .op(op_q), .a(a_q[i*8 +: 8]), .b(b_q[i*8 +: 8]),
         .res(res8[i*8 +: 8]), .sat(sat8[i])
      );
   end

   for (genvar i = 0; i < XLEN/16; i++) begin : g_l16
      alu_simd_lane #(.W(16)) u_lane (
         .op(op_q), .a(a_q[i*16 +: 16]), .b(b_q[i*16 +: 16]),
         .res(res16[i*16 +: 16]), .sat(sat16[i])
      );
   end

   for (genvar i = 0; i < XLEN/32; i++) begin : g_l32
      alu_simd_lane #(.W(32)) u_lane (
         .op(op_q), .a(a_q[i*32 +: 32]), .b(b_q[i*32 +: 32]),
         .res(res32[i*32 +: 32]), .sat(sat32[i])
      );
   end

   if (XLEN == 64) begin : g_l64
      alu_simd_lane #(.W(64)) u_lane (
         .op(op_q), .a(a_q), .b(b_q), .res(res64), .sat(sat64)
      );
   end else begin : g_no64
      assign res64 = '0;
      assign sat64 = 1'b0;
   end

   // A 64-bit element request on a 32-bit datapath falls back to 32-bit lanes.
   always_comb begin
      ew_eff = ew_q;
      if (XLEN == 32 && ew_q == 2'b11) ew_eff = 2'b10;
      lane_res = res8;
      lane_sat = |sat8;
      case (ew_eff)
         2'b01: begin lane_res = res16; lane_sat = |sat16; end
         2'b10: begin lane_res = res32; lane_sat = |sat32; end
         2'b11: begin lane_res = res64; lane_sat = sat64;  end
         default: ;
      endcase
   end

   if (PIPE_DEPTH == 1) begin : g_direct
      assign result_o   = lane_res;
      assign sat_o      = lane_sat;
      assign trans_id_o = id_q;
   end else begin : g_delay
      logic [XLEN-1:0]          res_q [PIPE_DEPTH-1];
      logic [TRANS_ID_BITS-1:0] tid_q [PIPE_DEPTH-1];
      logic [PIPE_DEPTH-2:0]    sat_q;

      // NOTE: these payload arrays are a handful of flops, not a RAM, and are
      // reset so the outputs read zero out of reset.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            for (int m = 0; m < PIPE_DEPTH-1; m++) begin
               res_q[m] <= '0;
               tid_q[m] <= '0;
            end
            sat_q <= '0;
         end else begin
            if (go[1]) begin
               res_q[0] <= lane_res;
               sat_q[0] <= lane_sat;
               tid_q[0] <= id_q;
            end
            for (int m = 1; m < PIPE_DEPTH-1; m++) begin
               if (go[m+1]) begin
                  res_q[m] <= res_q[m-1];
                  sat_q[m] <= sat_q[m-1];
                  tid_q[m] <= tid_q[m-1];
               end
            end
         end
      end

      assign result_o   = res_q[PIPE_DEPTH-2];
      assign sat_o      = sat_q[PIPE_DEPTH-2];
      assign trans_id_o = tid_q[PIPE_DEPTH-2];
   end

   // Set has priority over clear when both land on the same edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sticky <= 1'b0;
      end else if (vld[PIPE_DEPTH-1] && ready_i && sat_o) begin
         sticky <= 1'b1;
      end else if (clear_sat_i) begin
         sticky <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_simd.sv
// Scoreboard bench for alu_simd: directed vectors push expectations, a
// negedge monitor pops and compares on every result handshake.

module tb_alu_simd;
   import alu_simd_pkg::*;

   localparam int XLEN = 64;
   localparam int PD   = 2;
   localparam int TB   = 3;

   typedef struct packed {
      logic [63:0] res;
      logic        sat;
      logic [2:0]  id;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_i;
   logic            valid_i;
   logic            ready_o;
   logic [4:0]      op_i;
   logic [1:0]      ew_i;
   logic [XLEN-1:0] operand_a_i;
   logic [XLEN-1:0] operand_b_i;
   logic [TB-1:0]   trans_id_i;
   logic            valid_o;
   logic            ready_i;
   logic [XLEN-1:0] result_o;
   logic [TB-1:0]   trans_id_o;
   logic            sat_o;
   logic            sat_sticky_o;
   logic            clear_sat_i;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   n_acc = 0;
   int   n_del = 0;
   bit   rand_rdy = 1'b0;
   bit   chk_rdy  = 1'b0;

   alu_simd #(.XLEN(XLEN), .PIPE_DEPTH(PD), .TRANS_ID_BITS(TB)) dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .op_i(op_i), .ew_i(ew_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
      .trans_id_i(trans_id_i), .valid_o(valid_o), .ready_i(ready_i),
      .result_o(result_o), .trans_id_o(trans_id_o), .sat_o(sat_o),
      .sat_sticky_o(sat_sticky_o), .clear_sat_i(clear_sat_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [4:0] op, input logic [1:0] ew, input logic [63:0] a,
                       input logic [63:0] b, input logic [2:0] id,
                       input logic [63:0] res, input logic sat);
      exp_t e;
      int   n   = 0;
      bit   acc = 1'b0;
      op_i = op; ew_i = ew; operand_a_i = a; operand_b_i = b; trans_id_i = id;
      valid_i = 1'b1;
      e.res = res; e.sat = sat; e.id = id;
      exp_q.push_back(e);
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = ready_o;
         step();
         n++;
      end
      check($sformatf("accept id%0d", id), 64'(acc), 64'd1);
      if (acc) n_acc++;
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         step();
         n++;
      end
      check("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   // Randomised back-pressure, changed just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin : mon
      int   occ;
      exp_t e;
      if (!rst_i) begin
         occ = n_acc - n_del;
         if (chk_rdy) check("ready_o_rule", 64'(ready_o), 64'((occ < PD) || ready_i));
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 64'(valid_o), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("result id%0d", e.id), result_o, e.res);
               check($sformatf("sat id%0d", e.id), 64'(sat_o), 64'(e.sat));
               check($sformatf("tag id%0d", e.id), 64'(trans_id_o), 64'(e.id));
            end
            n_del++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int base;
      int stale;
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; clear_sat_i = 1'b0;
      op_i = '0; ew_i = '0; operand_a_i = '0; operand_b_i = '0; trans_id_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst valid_o", 64'(valid_o), 64'd0);
      check("rst ready_o", 64'(ready_o), 64'd1);
      check("rst result_o", result_o, 64'd0);
      check("rst trans_id_o", 64'(trans_id_o), 64'd0);
      check("rst sat_o", 64'(sat_o), 64'd0);
      check("rst sticky", 64'(sat_sticky_o), 64'd0);
      step();
      rst_i = 1'b0;

      // Latency: accepted at edge T, valid_o seen after edge T+1.
      send(OP_ADD, 2'd3, 64'd5, 64'd7, 3'd6, 64'd12, 1'b0);
      @(negedge clk);
      check("lat early valid_o", 64'(valid_o), 64'd0);
      step();
      @(negedge clk);
      check("lat valid_o", 64'(valid_o), 64'd1);
      step();
      drain();

      // Sticky set, then clear.
      send(OP_ADDUS, 2'd0, 64'hF0F0F0F0F0F0F0F0, 64'h2020202020202020, 3'd0,
           64'hFFFFFFFFFFFFFFFF, 1'b1);
      drain();
      @(negedge clk);
      check("sticky set", 64'(sat_sticky_o), 64'd1);
      step();
      clear_sat_i = 1'b1;
      step();
      clear_sat_i = 1'b0;
      @(negedge clk);
      check("sticky cleared", 64'(sat_sticky_o), 64'd0);
      step();

      // Clear held while a saturating result retires: set wins, then clear acts.
      clear_sat_i = 1'b1;
      send(OP_ADDSS, 2'd0, 64'h7F, 64'h01, 3'd1, 64'h7F, 1'b1);
      drain();
      @(negedge clk);
      check("sticky set wins", 64'(sat_sticky_o), 64'd1);
      step();
      @(negedge clk);
      check("sticky clear after", 64'(sat_sticky_o), 64'd0);
      step();
      clear_sat_i = 1'b0;

      // Directed lane vectors.
      send(OP_ADDSS, 2'd1, 64'h7FFF7FFF7FFF7FFF, 64'h0001000100010001, 3'd1, 64'h7FFF7FFF7FFF7FFF, 1'b1);
      send(OP_SUBSS, 2'd1, 64'h8000800080008000, 64'h0001000100010001, 3'd2, 64'h8000800080008000, 1'b1);
      send(OP_ADD,   2'd1, 64'h7FFF7FFF7FFF7FFF, 64'h0001000100010001, 3'd3, 64'h8000800080008000, 1'b0);
      send(OP_SRA,   2'd2, 64'h8000000000000010, 64'h0000000400000001, 3'd4, 64'hF800000000000008, 1'b0);
      send(OP_SLL,   2'd2, 64'h8000000000000010, 64'h0000000400000001, 3'd5, 64'h0000000000000020, 1'b0);
      send(OP_CMPLT, 2'd0, 64'h01FF, 64'h0, 3'd6, 64'h00000000000000FF, 1'b0);
      send(OP_ADD,   2'd0, 64'hFF, 64'h01, 3'd7, 64'h0, 1'b0);
      send(OP_SUBUS, 2'd0, 64'h1005, 64'h0810, 3'd0, 64'h0800, 1'b1);
      send(OP_SUBSS, 2'd0, 64'h7F, 64'h80, 3'd1, 64'h7F, 1'b1);
      send(OP_MIN,   2'd1, 64'h80000005FFFF0003, 64'h0001000700010002, 3'd2, 64'h80000005FFFF0002, 1'b0);
      send(OP_MAXU,  2'd1, 64'h80000005FFFF0003, 64'h0001000700010002, 3'd3, 64'h80000007FFFF0003, 1'b0);
      send(OP_CMPEQ, 2'd3, 64'h1234, 64'h1234, 3'd4, 64'hFFFFFFFFFFFFFFFF, 1'b0);
      send(OP_CMPLTU, 2'd2, 64'h00000001FFFFFFFF, 64'h0000000200000001, 3'd5, 64'hFFFFFFFF00000000, 1'b0);
      send(OP_SRL,   2'd0, 64'h8080808080808080, 64'h0F0F0F0F0F0F0F0F, 3'd6, 64'h0101010101010101, 1'b0);
      send(OP_XOR,   2'd0, 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, 3'd7, 64'hF00FF00FF00FF00F, 1'b0);
      send(OP_AND,   2'd2, 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, 3'd0, 64'h0F000F000F000F00, 1'b0);
      send(OP_OR,    2'd1, 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, 3'd1, 64'hFF0FFF0FFF0FFF0F, 1'b0);
      send(5'd19,    2'd0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd2, 64'h0, 1'b0);
      send(OP_SUB,   2'd3, 64'h0, 64'h1, 3'd3, 64'hFFFFFFFFFFFFFFFF, 1'b0);
      send(OP_MAX,   2'd0, 64'h80, 64'h7F, 3'd4, 64'h7F, 1'b0);
      send(OP_MINU,  2'd3, 64'hFFFFFFFFFFFFFFFE, 64'h1, 3'd5, 64'h1, 1'b0);
      drain();

      // Back-to-back with random back-pressure; tags 0..7,0,1.
      base = n_del;
      rand_rdy = 1'b1;
      chk_rdy  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send(OP_ADD, 2'd3, 64'(i) << 8, 64'(i), 3'(i % 8), 64'(i) * 64'h101, 1'b0);
      end
      rand_rdy = 1'b0;
      ready_i  = 1'b1;
      drain();
      chk_rdy  = 1'b0;
      check("b2b delivered", 64'(n_del - base), 64'd10);

      // Reset with two ops in flight and the sticky flag set.
      send(OP_SUBUS, 2'd0, 64'h0, 64'h1, 3'd6, 64'h0, 1'b1);
      drain();
      ready_i = 1'b0;
      send(OP_ADD, 2'd3, 64'd1, 64'd1, 3'd3, 64'd2, 1'b0);
      send(OP_ADD, 2'd3, 64'd2, 64'd2, 3'd4, 64'd4, 1'b0);
      rst_i = 1'b1;
      @(negedge clk);
      check("rst mid ready_o", 64'(ready_o), 64'd1);
      step();
      @(negedge clk);
      check("rst mid valid_o", 64'(valid_o), 64'd0);
      check("rst mid sticky", 64'(sat_sticky_o), 64'd0);
      check("rst mid result_o", result_o, 64'd0);
      check("rst mid trans_id_o", 64'(trans_id_o), 64'd0);
      exp_q.delete();
      n_del = n_acc;
      step();
      rst_i   = 1'b0;
      ready_i = 1'b1;
      stale   = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (valid_o) stale++;
         step();
      end
      check("no stale after reset", 64'(stale), 64'd0);

      send(OP_SUB, 2'd0, 64'h0102, 64'h0201, 3'd5, 64'hFF01, 1'b0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
